// File: rtl/vga_sync_pkg.sv
// Default 640x480@60 timing, coordinate width and output bundle for vga_sync_gen.
// Shared by the top (vga_sync_gen) and its axis counters.
package vga_sync_pkg;

    localparam int unsigned COORD_W = 16;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] column;
        logic               enable;
        logic               hsync;
        logic               vsync;
        logic               frame_start;
    } sync_out_t;

    // Syncs are active-low, so the idle bundle keeps them high.
    localparam sync_out_t SYNC_OUT_RESET = '{
        row:         '0,
        column:      '0,
        enable:      1'b0,
        hsync:       1'b1,
        vsync:       1'b1,
        frame_start: 1'b0
    };

    function automatic logic in_window(input logic [31:0] pos,
                                       input logic [31:0] lo,
                                       input logic [31:0] len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-at-limit counter for one raster axis; wrap pulses on the increment
// that returns the count from LIMIT-1 to zero.
module vga_axis_counter #(
    parameter int unsigned LIMIT = 800,
    parameter int unsigned WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == WIDTH'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign wrap  = inc && at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: registered coordinates, visible-area enable and
// active-low syncs. Define VGA_SYNC_CE_EN to add the pix_ce advance enable.
module vga_sync_gen
    import vga_sync_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef VGA_SYNC_CE_EN
    input  logic               pix_ce,
`endif
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] column,
    output logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    logic           advance;
    logic           h_wrap;
    logic           v_wrap;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic [31:0]    h_pos;
    logic [31:0]    v_pos;
    logic           at_origin_q;
    logic           at_origin_d;
    sync_out_t      out_q;
    sync_out_t      out_d;

`ifdef VGA_SYNC_CE_EN
    assign advance = pix_ce;
`else
    assign advance = 1'b1;
`endif

    vga_axis_counter #(
        .LIMIT (H_TOTAL),
        .WIDTH (H_W)
    ) u_h_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (advance),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .LIMIT (V_TOTAL),
        .WIDTH (V_W)
    ) u_v_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    assign h_pos = 32'(h_cnt);
    assign v_pos = 32'(v_cnt);

    // Tracks "counters sit at (0,0)" from the frame wrap instead of a wide compare.
    always_comb begin
        at_origin_d = at_origin_q;
        if (advance) begin
            at_origin_d = v_wrap;
        end
    end

    always_comb begin
        out_d = out_q;
        if (advance) begin
            out_d.column      = COORD_W'(h_cnt);
            out_d.row         = COORD_W'(v_cnt);
            out_d.enable      = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
            out_d.hsync       = !in_window(h_pos, H_ACTIVE + H_FP, H_SYNC);
            out_d.vsync       = !in_window(v_pos, V_ACTIVE + V_FP, V_SYNC);
            out_d.frame_start = at_origin_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_origin_q <= 1'b1;
            out_q       <= SYNC_OUT_RESET;
        end else begin
            at_origin_q <= at_origin_d;
            out_q       <= out_d;
        end
    end

    assign row         = out_q.row;
    assign column      = out_q.column;
    assign enable      = out_q.enable;
    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default-timing instance for reset and line
// checks, reduced-timing instance (60x40 total) for frame, mid-frame reset and pix_ce.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a;
    logic        rst_b;
`ifdef VGA_SYNC_CE_EN
    logic        pix_ce;
`endif

    logic [15:0] row_a, column_a, row_b, column_b;
    logic        enable_a, hsync_a, vsync_a, frame_start_a;
    logic        enable_b, hsync_b, vsync_b, frame_start_b;

    int vec_count  = 0;
    int miss_count = 0;

    vga_sync_gen dut_a (
        .clk         (clk),
        .rst_n       (rst_a),
`ifdef VGA_SYNC_CE_EN
        .pix_ce      (pix_ce),
`endif
        .row         (row_a),
        .column      (column_a),
        .enable      (enable_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .frame_start (frame_start_a)
    );

    // Small raster: hsync low at columns 44..49, vsync low at rows 33..34.
    vga_sync_gen #(
        .H_ACTIVE (40), .H_FP (4), .H_SYNC (6), .H_BP (10),
        .V_ACTIVE (30), .V_FP (3), .V_SYNC (2), .V_BP (5)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_b),
`ifdef VGA_SYNC_CE_EN
        .pix_ce      (pix_ce),
`endif
        .row         (row_b),
        .column      (column_b),
        .enable      (enable_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .frame_start (frame_start_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
    endtask

    task automatic runResetTest();
        rst_a = 1'b0;
        rst_b = 1'b0;
`ifdef VGA_SYNC_CE_EN
        pix_ce = 1'b1;
`endif
        repeat (3) applyStimulus();
        checkOutput("rst_column", 32'(column_a), 0);
        checkOutput("rst_row", 32'(row_a), 0);
        checkOutput("rst_enable", 32'(enable_a), 0);
        checkOutput("rst_hsync", 32'(hsync_a), 1);
        checkOutput("rst_vsync", 32'(vsync_a), 1);
        checkOutput("rst_frame_start", 32'(frame_start_a), 0);
        checkOutput("rst_b_enable", 32'(enable_b), 0);
        checkOutput("rst_b_frame_start", 32'(frame_start_b), 0);
    endtask

    task automatic runLineTest();
        int en_cnt   = 0;
        int en_last  = -1;
        int hs_cnt   = 0;
        int hs_first = -1;
        int pos_err  = 0;
        rst_a = 1'b1;
        for (int i = 0; i <= 800; i++) begin
            applyStimulus();
            if (i == 0) begin
                checkOutput("first_column", 32'(column_a), 0);
                checkOutput("first_row", 32'(row_a), 0);
                checkOutput("first_enable", 32'(enable_a), 1);
                checkOutput("first_frame_start", 32'(frame_start_a), 1);
                checkOutput("first_hsync", 32'(hsync_a), 1);
                checkOutput("first_vsync", 32'(vsync_a), 1);
            end
            if (i < 800) begin
                if (column_a != 16'(i) || row_a != 16'd0 || !vsync_a) pos_err++;
                if (frame_start_a && i != 0) pos_err++;
                if (enable_a) begin
                    en_cnt++;
                    en_last = i;
                end
                if (!hsync_a) begin
                    if (hs_cnt == 0) hs_first = int'(column_a);
                    hs_cnt++;
                end
            end else begin
                checkOutput("line_wrap_column", 32'(column_a), 0);
                checkOutput("line_wrap_row", 32'(row_a), 1);
                checkOutput("line_wrap_enable", 32'(enable_a), 1);
            end
        end
        checkOutput("line_enable_edges", en_cnt, 640);
        checkOutput("line_enable_last_col", en_last, 639);
        checkOutput("line_hsync_edges", hs_cnt, 96);
        checkOutput("line_hsync_first_col", hs_first, 656);
        checkOutput("line_position_errors", pos_err, 0);
    endtask

    task automatic runFrameTest();
        int vs_cnt  = 0;
        int vs_bad  = 0;
        int en_cnt  = 0;
        int fs_cnt  = 0;
        int fs_prev = -1;
        int fs_gap  = -1;
        rst_b = 1'b1;
        for (int i = 0; i <= 2400; i++) begin
            applyStimulus();
            if (frame_start_b) begin
                if (fs_prev >= 0) fs_gap = i - fs_prev;
                fs_prev = i;
                fs_cnt++;
            end
            if (i < 2400) begin
                if (!vsync_b) vs_cnt++;
                if ((!vsync_b) != (row_b == 16'd33 || row_b == 16'd34)) vs_bad++;
                if (enable_b) en_cnt++;
            end
        end
        checkOutput("frame_vsync_edges", vs_cnt, 120);
        checkOutput("frame_vsync_rows", vs_bad, 0);
        checkOutput("frame_enable_edges", en_cnt, 1200);
        checkOutput("frame_start_count", fs_cnt, 2);
        checkOutput("frame_start_gap", fs_gap, 2400);
        checkOutput("frame_wrap_row", 32'(row_b), 0);
    endtask

    task automatic runMidResetTest();
        logic found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            applyStimulus();
            if (row_b == 16'd20 && column_b == 16'd13) found = 1'b1;
        end
        checkOutput("mid_reached_20_13", 32'(found), 1);
        rst_b = 1'b0;
        #1;
        checkOutput("mid_rst_column", 32'(column_b), 0);
        checkOutput("mid_rst_row", 32'(row_b), 0);
        checkOutput("mid_rst_enable", 32'(enable_b), 0);
        checkOutput("mid_rst_hsync", 32'(hsync_b), 1);
        checkOutput("mid_rst_vsync", 32'(vsync_b), 1);
        checkOutput("mid_rst_frame_start", 32'(frame_start_b), 0);
        repeat (3) applyStimulus();
        checkOutput("mid_rst_hold_enable", 32'(enable_b), 0);
        rst_b = 1'b1;
        applyStimulus();
        checkOutput("restart_column", 32'(column_b), 0);
        checkOutput("restart_row", 32'(row_b), 0);
        checkOutput("restart_enable", 32'(enable_b), 1);
        checkOutput("restart_frame_start", 32'(frame_start_b), 1);
        checkOutput("restart_hsync", 32'(hsync_b), 1);
        checkOutput("restart_vsync", 32'(vsync_b), 1);
        applyStimulus();
        checkOutput("restart_next_column", 32'(column_b), 1);
        checkOutput("restart_next_frame_start", 32'(frame_start_b), 0);
    endtask

`ifdef VGA_SYNC_CE_EN
    task automatic runCeTest();
        int frozen_err = 0;
        int start      = -1;
        int len        = -1;
        pix_ce = 1'b0;
        repeat (50) begin
            applyStimulus();
            if (column_b != 16'd1 || row_b != 16'd0 || !enable_b || frame_start_b || !hsync_b || !vsync_b)
                frozen_err++;
        end
        checkOutput("ce_frozen_outputs", frozen_err, 0);
        for (int i = 0; i < 400 && len < 0; i++) begin
            pix_ce = ~pix_ce;
            applyStimulus();
            if (column_b == 16'd0 && row_b == 16'd1 && start < 0) start = i;
            if (column_b == 16'd0 && row_b == 16'd2 && start >= 0 && len < 0) len = i - start;
        end
        checkOutput("ce_line_edges", len, 120);
    endtask
`endif

    initial begin
        runResetTest();
        runLineTest();
        runFrameTest();
        runMidResetTest();
`ifdef VGA_SYNC_CE_EN
        runCeTest();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch widths in lines.
REQ-005 Port clk, input, 1, pixel clock; one clock, all logic on its rising edge.
REQ-006 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 Port pix_ce, input, 1, pixel advance enable; present only with VGA_SYNC_CE_EN.
REQ-008 Port row, output, 16, current line index, feeds the pixel-lookup stage.
REQ-009 Port column, output, 16, current pixel index within the line.
REQ-010 Port enable, output, 1, high when (column, row) lies in the visible area.
REQ-011 Port hsync, output, 1, horizontal sync, active-low.
REQ-012 Port vsync, output, 1, vertical sync, active-low.
REQ-013 Port frame_start, output, 1, one-advance pulse marking pixel (0,0).

Function
REQ-014 Internal counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-015 On each advance, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments; at v_cnt = V_TOTAL-1 with the h wrap, v_cnt wraps to 0.
REQ-016 All outputs are registered; on each advance they take the decode of the pre-advance (h_cnt, v_cnt), giving one advance of latency.
REQ-017 column = h_cnt and row = v_cnt zero-extended to 16 bits, including during blanking.
REQ-018 enable = (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
REQ-019 hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-020 vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line.
REQ-021 frame_start = 1 iff h_cnt = 0 and v_cnt = 0.
REQ-022 Without an advance, counters and outputs hold their values, with no pulse repetition beyond the held value.

Reset
REQ-023 With rst_n low: h_cnt = 0, v_cnt = 0, row = 0, column = 0, enable = 0, hsync = 1, vsync = 1, frame_start = 0.
REQ-024 Reset asserted mid-frame takes effect immediately; the first advance after release outputs pixel (0,0) with enable = 1 and frame_start = 1.

Configuration
REQ-025 With VGA_SYNC_CE_EN defined, port pix_ce exists and an advance occurs only on clk edges with pix_ce = 1.
REQ-026 Without VGA_SYNC_CE_EN, pix_ce is absent and every clk edge is an advance.

Structure
REQ-027 Package vga_sync_pkg holds the default 640x480@60 timing constants, H_TOTAL/V_TOTAL derivation and the 16-bit coordinate width constant.
REQ-028 Sub-module vga_axis_counter (wrap-at-limit counter with increment input and wrap output) is instantiated twice: horizontal, and vertical chained on the horizontal wrap.

Verification
REQ-029 Release reset, first edge -> column = 0, row = 0, enable = 1, frame_start = 1, hsync = 1, vsync = 1.
REQ-030 Run one line -> enable high for exactly 640 edges; hsync low for exactly 96 edges starting at column = 656; column wraps 799 -> 0 with row incrementing.
REQ-031 Run one full frame -> vsync low exactly while row = 490..491 (1600 edges); frame_start pulses exactly 420000 edges apart.
REQ-032 Assert rst_n at row = 300, column = 123, release -> outputs at reset values, then restart at (0,0) per REQ-024.
REQ-033 With VGA_SYNC_CE_EN, pix_ce = 1 on every other edge -> line length 1600 clk edges; pix_ce held 0 for 50 edges -> all outputs frozen.
